jdizigzag_d1: RTL and testbench
===============================

Name: jdizigzag_d1

Overview:
- Inverse-zigzag reorder stage directly downstream of the JPEG dequantizer in the non-parallel decode chain.
- Accepts dequantized coefficients in zigzag scan order, 64 per 8x8 block.
- Emits each block in raster (row-major) order to the IDCT stage.
- Ping-pong buffers the blocks so one block can be written while the previous one drains.

Parameters:
- WIDTH, 16, coefficient width on both streams.
- NBUF, 2, number of 64-entry block buffers. Fixed at 2; other values are unsupported.

Ports:
- clock  input  1  single system clock; everything is sampled on its rising edge.
- reset  input  1  synchronous reset, active-low.
- inStream_d  input  WIDTH  coefficient in zigzag order.
- inStream_e  input  1  end-of-stream token flag; qualified by inStream_v.
- inStream_v  input  1  input word/token valid.
- inStream_b  output  1  back-pressure to the dequantizer; 1 = cannot accept.
- outStream_d  output  WIDTH  coefficient in raster order.
- outStream_e  output  1  end-of-stream token flag.
- outStream_v  output  1  output valid.
- outStream_b  input  1  back-pressure from the IDCT.

Behaviour:
- Handshake:
  - A transfer occurs on a clock edge where v=1 and b=0.
  - d/e/v are held stable while v=1 and b=1.
  - An e=1 token carries no coefficient; d is ignored on input and driven 0 on output.
- Reset (reset=0 at an edge), regardless of state, including mid-block:
  - outStream_v=0, outStream_e=0, outStream_d=0, inStream_b=1.
  - Both buffers empty, write index k=0, read index r=0, pending-eos cleared, FSM to FILL.
  - inStream_b drops to 0 on the first edge with reset=1.
- Write side:
  - A 64-entry zigzag ROM (standard JPEG table) maps the k-th accepted coefficient to raster address zz[k], e.g. zz[0..9]=0,1,8,16,9,2,3,10,17,24; zz[63]=63.
  - The coefficient is written to the current write buffer at zz[k]; k increments and wraps 63->0.
  - On the wrap the buffer is marked full and the write pointer toggles.
- inStream_b=1 when any of the following holds:
  - both buffers are full;
  - the FSM is in PAD;
  - an eos is pending.
- Read side:
  - A full buffer is read at addresses r=0..63 sequentially, using a registered RAM read.
  - The output register advances only when outStream_v=0 or outStream_b=0, so there are no bubbles under no back-pressure.
  - After raster 63 is transferred the buffer is marked empty and the read pointer toggles.
- Latency:
  - With the read side idle and outStream_b=0, raster 0 of a block is valid exactly 2 cycles after the edge accepting its 64th coefficient.
  - Steady-state throughput is 1 coefficient per cycle.
- Simultaneous events:
  - A buffer freeing and a buffer filling on the same edge are both honoured.
  - inStream_b is recomputed from next-state values, so it is low in the cycle after a free when one buffer was full.
- Write-side FSM (FILL / PAD / EOSWAIT):
  - FILL, eos accepted with k=0: go to EOSWAIT.
  - FILL, eos accepted with k>0: go to PAD. PAD writes 0 to zz[k..63], one per cycle, ignoring output back-pressure. The block then completes normally and the FSM goes to EOSWAIT.
  - EOSWAIT: wait until both buffers are empty and the last coefficient has transferred. Then present outStream_e=1, outStream_v=1 for one token. On its transfer, return to FILL with k=0 and clear pending-eos.
- Arithmetic: none on data. Coefficients pass through bit-exact; indices are 6-bit.

Test Plan:
- Single block, inputs d=k for k=0..63, outStream_b=0:
  - outputs in raster order are d[r]=zz^-1[r], i.e. 0,1,5,6,14,15,27,28, ...
  - first valid exactly 2 cycles after the 64th accept.
- Four back-to-back blocks (block b holds d=64b+k), output back-pressure outStream_b=0:
  - no input stall after the first block; no output bubbles;
  - 256 outputs are correctly reordered.
- outStream_b held 1 for 200 cycles during block 0 output while blocks 1–2 arrive:
  - inStream_b=1 once blocks 1 and 2 are both buffered;
  - outStream_d holds stable throughout;
  - all data is intact after release.
- eos after 10 coefficients (d=1..10):
  - the block is emitted with raster positions zz[0..9]=1..10 and all others 0;
  - then exactly one token with e=1, v=1, d=0.
- eos at a block boundary after 2 full blocks:
  - 128 coefficients, then the eos token;
  - no padded block is emitted.
- reset=0 asserted mid-block (k=37) for 1 cycle, then a fresh block is sent:
  - outStream_v=0 and inStream_b=1 during reset;
  - no stale coefficients appear;
  - the new block is output correctly.

Source files
------------

// File: rtl/jdizigzag_d1.sv
// jdizigzag_d1: inverse-zigzag reorder stage between dequantizer and IDCT.
// Zigzag-ordered coefficients are written into one of two ping-pong block buffers and drained in raster order.
module jdizigzag_d1 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NBUF  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] inStream_d,
  input  logic             inStream_e,
  input  logic             inStream_v,
  output logic             inStream_b,
  output logic [WIDTH-1:0] outStream_d,
  output logic             outStream_e,
  output logic             outStream_v,
  input  logic             outStream_b
);

  localparam int unsigned DEPTH = NBUF * 64;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PAD     = 2'd1,
    EOSWAIT = 2'd2
  } wrState_t;

  wrState_t         state, nState;
  logic [5:0]       k, nK;
  logic [5:0]       r, nR;
  logic [1:0]       full, nFull;
  logic             wrPtr, nWrPtr;
  logic             rdPtr, nRdPtr;
  logic             eosPending, nEosPending;
  logic             ramValid, nRamValid;
  logic [WIDTH-1:0] ramQ;
  logic [WIDTH-1:0] nOutD;
  logic             nOutE, nOutV, nInB;

  logic             advance, accept, wrEn, rdEn;
  logic [6:0]       wrAddr, rdAddr;
  logic [WIDTH-1:0] wrData;

  logic [WIDTH-1:0] mem [DEPTH];

  // Standard JPEG zigzag table: scan index -> raster address.
  function automatic logic [5:0] zzRom(input logic [5:0] idx);
    logic [5:0] a;
    case (idx)
      6'd0:  a = 6'd0;
      6'd1:  a = 6'd1;
      6'd2:  a = 6'd8;
      6'd3:  a = 6'd16;
      6'd4:  a = 6'd9;
      6'd5:  a = 6'd2;
      6'd6:  a = 6'd3;
      6'd7:  a = 6'd10;
      6'd8:  a = 6'd17;
      6'd9:  a = 6'd24;
      6'd10: a = 6'd32;
      6'd11: a = 6'd25;
      6'd12: a = 6'd18;
      6'd13: a = 6'd11;
      6'd14: a = 6'd4;
      6'd15: a = 6'd5;
      6'd16: a = 6'd12;
      6'd17: a = 6'd19;
      6'd18: a = 6'd26;
      6'd19: a = 6'd33;
      6'd20: a = 6'd40;
      6'd21: a = 6'd48;
      6'd22: a = 6'd41;
      6'd23: a = 6'd34;
      6'd24: a = 6'd27;
      6'd25: a = 6'd20;
      6'd26: a = 6'd13;
      6'd27: a = 6'd6;
      6'd28: a = 6'd7;
      6'd29: a = 6'd14;
      6'd30: a = 6'd21;
      6'd31: a = 6'd28;
      6'd32: a = 6'd35;
      6'd33: a = 6'd42;
      6'd34: a = 6'd49;
      6'd35: a = 6'd56;
      6'd36: a = 6'd57;
      6'd37: a = 6'd50;
      6'd38: a = 6'd43;
      6'd39: a = 6'd36;
      6'd40: a = 6'd29;
      6'd41: a = 6'd22;
      6'd42: a = 6'd15;
      6'd43: a = 6'd23;
      6'd44: a = 6'd30;
      6'd45: a = 6'd37;
      6'd46: a = 6'd44;
      6'd47: a = 6'd51;
      6'd48: a = 6'd58;
      6'd49: a = 6'd59;
      6'd50: a = 6'd52;
      6'd51: a = 6'd45;
      6'd52: a = 6'd38;
      6'd53: a = 6'd31;
      6'd54: a = 6'd39;
      6'd55: a = 6'd46;
      6'd56: a = 6'd53;
      6'd57: a = 6'd60;
      6'd58: a = 6'd61;
      6'd59: a = 6'd54;
      6'd60: a = 6'd47;
      6'd61: a = 6'd55;
      6'd62: a = 6'd62;
      default: a = 6'd63;
    endcase
    return a;
  endfunction

  // Next-state logic for the write FSM, buffer flags, read pipeline and output register.
  always_comb begin
    nState      = state;
    nK          = k;
    nR          = r;
    nFull       = full;
    nWrPtr      = wrPtr;
    nRdPtr      = rdPtr;
    nEosPending = eosPending;
    nRamValid   = ramValid;
    nOutD       = outStream_d;
    nOutE       = outStream_e;
    nOutV       = outStream_v;

    advance = !outStream_v || !outStream_b;
    accept  = inStream_v && !inStream_b;
    wrEn    = (accept && !inStream_e) || (state == PAD);
    wrAddr  = {wrPtr, zzRom(k)};
    wrData  = (state == PAD) ? '0 : inStream_d;
    rdEn    = full[rdPtr] && (!ramValid || advance);
    rdAddr  = {rdPtr, r};

    if (wrEn) begin
      nK = k + 6'd1;
      if (k == 6'd63) begin
        nFull[wrPtr] = 1'b1;
        nWrPtr       = ~wrPtr;
      end
    end

    case (state)
      FILL: begin
        if (accept && inStream_e) begin
          nEosPending = 1'b1;
          nState      = (k == 6'd0) ? EOSWAIT : PAD;
        end
      end
      PAD: begin
        if (k == 6'd63) nState = EOSWAIT;
      end
      EOSWAIT: begin
        if (outStream_v && outStream_e && !outStream_b) begin
          nState      = FILL;
          nEosPending = 1'b0;
          nK          = 6'd0;
        end
      end
      default: nState = FILL;
    endcase

    // Freeing happens once the last raster word has left the buffer for the pipeline.
    if (rdEn) begin
      nR = r + 6'd1;
      if (r == 6'd63) begin
        nFull[rdPtr] = 1'b0;
        nRdPtr       = ~rdPtr;
      end
    end

    if (rdEn)         nRamValid = 1'b1;
    else if (advance) nRamValid = 1'b0;

    if (advance) begin
      nOutV = ramValid;
      nOutE = 1'b0;
      nOutD = ramValid ? ramQ : '0;
      if (state == EOSWAIT && !full[0] && !full[1] && !ramValid && !outStream_e) begin
        nOutV = 1'b1;
        nOutE = 1'b1;
        nOutD = '0;
      end
    end

    nInB = (nFull[0] && nFull[1]) || (nState == PAD) || nEosPending;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= FILL;
      k           <= 6'd0;
      r           <= 6'd0;
      full        <= 2'b00;
      wrPtr       <= 1'b0;
      rdPtr       <= 1'b0;
      eosPending  <= 1'b0;
      ramValid    <= 1'b0;
      outStream_d <= '0;
      outStream_e <= 1'b0;
      outStream_v <= 1'b0;
      inStream_b  <= 1'b1;
    end else begin
      state       <= nState;
      k           <= nK;
      r           <= nR;
      full        <= nFull;
      wrPtr       <= nWrPtr;
      rdPtr       <= nRdPtr;
      eosPending  <= nEosPending;
      ramValid    <= nRamValid;
      outStream_d <= nOutD;
      outStream_e <= nOutE;
      outStream_v <= nOutV;
      inStream_b  <= nInB;
    end
  end

  // Block RAM with registered read; contents need no reset since the full flags gate reads.
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) ramQ <= mem[rdAddr];
  end

endmodule

// File: tb/tb_jdizigzag_d1.sv
// Scoreboard bench for jdizigzag_d1: stimulus pushes expected raster words, a monitor pops on each output transfer.
module tb_jdizigzag_d1;
  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic             e;
    logic [WIDTH-1:0] d;
  } tok_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] inStream_d = '0;
  logic             inStream_e = 1'b0;
  logic             inStream_v = 1'b0;
  logic             inStream_b;
  logic [WIDTH-1:0] outStream_d;
  logic             outStream_e;
  logic             outStream_v;
  logic             outStream_b = 1'b0;

  tok_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   zz[64];
  int   inv[64];
  int   cyc = 0;
  int   xfers = 0;
  int   firstCyc = 0;
  int   lastCyc = 0;
  int   stallCount = 0;

  jdizigzag_d1 #(.WIDTH(WIDTH), .NBUF(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .inStream_d (inStream_d),
    .inStream_e (inStream_e),
    .inStream_v (inStream_v),
    .inStream_b (inStream_b),
    .outStream_d(outStream_d),
    .outStream_e(outStream_e),
    .outStream_v(outStream_v),
    .outStream_b(outStream_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every output transfer must match the head of the expected queue.
  always @(negedge clock) begin
    tok_t want;
    if (reset && outStream_v && !outStream_b) begin
      if (xfers == 0) firstCyc = cyc;
      lastCyc = cyc;
      xfers++;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got e=%0b d=%0h with empty queue", outStream_e, outStream_d);
      end else begin
        want = expQ.pop_front();
        if (want.e !== outStream_e || want.d !== outStream_d) begin
          failures++;
          $display("FAIL sb_word xfer=%0d got e=%0b d=%0h want e=%0b d=%0h",
                   xfers, outStream_e, outStream_d, want.e, want.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the word was accepted.
  task automatic sendWord(input logic [WIDTH-1:0] d, input logic e);
    int waitCyc;
    waitCyc = 0;
    inStream_v = 1'b1;
    inStream_d = d;
    inStream_e = e;
    @(negedge clock);
    while (inStream_b && waitCyc < 3000) begin
      stallCount++;
      waitCyc++;
      @(negedge clock);
    end
    if (inStream_b) begin
      checks++;
      failures++;
      $display("FAIL send_timeout inStream_b stuck at 1 for d=%0h", d);
    end
    tick();
  endtask

  task automatic idle();
    inStream_v = 1'b0;
    inStream_e = 1'b0;
    inStream_d = '0;
  endtask

  task automatic sendBlock(input int base);
    for (int i = 0; i < 64; i++) sendWord(WIDTH'(base + i), 1'b0);
  endtask

  task automatic pushBlock(input int base);
    tok_t t;
    for (int i = 0; i < 64; i++) begin
      t.e = 1'b0;
      t.d = WIDTH'(base + inv[i]);
      expQ.push_back(t);
    end
  endtask

  task automatic pushToken();
    tok_t t;
    t.e = 1'b1;
    t.d = '0;
    expQ.push_back(t);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || outStream_v) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(expQ.size()), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    tok_t t;
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tok_t t;
    // Build the zigzag walk by traversing anti-diagonals; inv maps raster -> scan index.
    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int row = (s < 7 ? s : 7); row >= (s > 7 ? s - 7 : 0); row--) begin
          zz[n] = row * 8 + (s - row);
          n++;
        end
      end else begin
        for (int row = (s > 7 ? s - 7 : 0); row <= (s < 7 ? s : 7); row++) begin
          zz[n] = row * 8 + (s - row);
          n++;
        end
      end
    end
    for (int i = 0; i < 64; i++) inv[zz[i]] = i;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_v", 32'(outStream_v), 32'd0);
    chk("rst_out_e", 32'(outStream_e), 32'd0);
    chk("rst_out_d", 32'(outStream_d), 32'd0);
    chk("rst_in_b", 32'(inStream_b), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_release_in_b", 32'(inStream_b), 32'd0);
    tick();

    // Single block, d=k, with latency check
    pushBlock(0);
    sendBlock(0);
    idle();
    @(negedge clock);
    chk("lat_cycle0_v", 32'(outStream_v), 32'd0);
    @(negedge clock);
    chk("lat_cycle1_v", 32'(outStream_v), 32'd0);
    @(negedge clock);
    chk("lat_cycle2_v", 32'(outStream_v), 32'd1);
    chk("lat_cycle2_d", 32'(outStream_d), 32'd0);
    waitDrain("single_drain");

    // Four back-to-back blocks, no input stalls after block 0, no output bubbles
    xfers = 0;
    for (int b = 0; b < 4; b++) pushBlock(64 * b);
    sendBlock(0);
    stallCount = 0;
    for (int b = 1; b < 4; b++) sendBlock(64 * b);
    idle();
    chk("b2b_in_stalls", 32'(stallCount), 32'd0);
    waitDrain("b2b_drain");
    chk("b2b_xfers", 32'(xfers), 32'd256);
    chk("b2b_no_bubble", 32'(lastCyc - firstCyc), 32'd255);

    // Output back-pressure for 200 cycles while further blocks arrive
    xfers = 0;
    for (int b = 0; b < 3; b++) pushBlock(1000 + 64 * b);
    fork
      begin
        for (int b = 0; b < 3; b++) sendBlock(1000 + 64 * b);
        idle();
      end
      begin
        int w;
        int unstable;
        logic [WIDTH-1:0] held;
        w = 0;
        unstable = 0;
        while (xfers < 5 && w < 1000) begin
          @(posedge clock);
          w++;
        end
        #1 outStream_b = 1'b1;
        @(negedge clock);
        held = outStream_d;
        for (int i = 0; i < 199; i++) begin
          @(negedge clock);
          if (outStream_d !== held || !outStream_v) unstable++;
        end
        chk("bp_stable", 32'(unstable), 32'd0);
        chk("bp_in_b_high", 32'(inStream_b), 32'd1);
        @(posedge clock);
        #1 outStream_b = 1'b0;
      end
    join
    waitDrain("bp_drain");
    chk("bp_xfers", 32'(xfers), 32'd192);

    // eos after 10 coefficients: padded block then one token
    xfers = 0;
    for (int i = 0; i < 64; i++) begin
      t.e = 1'b0;
      t.d = (inv[i] < 10) ? WIDTH'(inv[i] + 1) : '0;
      expQ.push_back(t);
    end
    pushToken();
    for (int i = 1; i <= 10; i++) sendWord(WIDTH'(i), 1'b0);
    sendWord(16'hDEAD, 1'b1);
    idle();
    @(negedge clock);
    chk("pad_in_b", 32'(inStream_b), 32'd1);
    waitDrain("eos_mid_drain");
    chk("eos_mid_xfers", 32'(xfers), 32'd65);

    // eos exactly on a block boundary after two blocks: no padded block
    xfers = 0;
    pushBlock(300);
    pushBlock(364);
    pushToken();
    sendBlock(300);
    sendBlock(364);
    sendWord('0, 1'b1);
    idle();
    waitDrain("eos_bound_drain");
    repeat (20) tick();
    chk("eos_bound_xfers", 32'(xfers), 32'd129);

    // Reset in mid-block (k=37), then a fresh block
    xfers = 0;
    for (int i = 0; i < 37; i++) sendWord(WIDTH'(500 + i), 1'b0);
    idle();
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_out_v", 32'(outStream_v), 32'd0);
    chk("midrst_out_d", 32'(outStream_d), 32'd0);
    chk("midrst_in_b", 32'(inStream_b), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_release_in_b", 32'(inStream_b), 32'd0);
    tick();
    pushBlock(700);
    sendBlock(700);
    idle();
    waitDrain("midrst_drain");
    repeat (10) tick();
    chk("midrst_xfers", 32'(xfers), 32'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
